// File: rtl/mac_fb_pkg.sv
// Shared types and constants for the Mac 512x512x1 framebuffer scanout block.
// Word address layout is {line[8:0], word_in_line[4:0]}.
package mac_fb_pkg;

  localparam int FB_WORDS_PER_LINE = 32;
  localparam int FB_LINES          = 512;
  localparam int FB_ADDR_W         = 14;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [15:0]          data;
  } fb_wr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    LOAD = 2'd2
  } slot_state_e;

  function automatic logic [FB_ADDR_W-1:0] fb_word_addr(input logic [8:0] y,
                                                         input logic [8:0] x);
    return {y, x[8:4]};
  endfunction

endpackage

// File: rtl/mac_fb_scanout_if.sv
// SPRAM port bundle: the scanout block is the master, the framebuffer RAM the slave.
interface mac_fb_scanout_if;
  import mac_fb_pkg::*;

  logic                 fb_wen;
  logic [FB_ADDR_W-1:0] fb_wr_addr;
  logic [15:0]          fb_wr_data;
  logic [FB_ADDR_W-1:0] fb_rd_addr;
  logic [15:0]          fb_rd_data;

  modport master (
    output fb_wen,
    output fb_wr_addr,
    output fb_wr_data,
    output fb_rd_addr,
    input  fb_rd_data
  );

  modport slave (
    input  fb_wen,
    input  fb_wr_addr,
    input  fb_wr_data,
    input  fb_rd_addr,
    output fb_rd_data
  );

endinterface

// File: rtl/mac_fb_wr_fifo.sv
// Small synchronous FIFO of deferred framebuffer writes; pointers carry one extra
// wrap bit so full and empty are told apart without a separate counter.
module mac_fb_wr_fifo
  import mac_fb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk_16mhz,
  input  logic   reset,
  input  logic   i_push,
  input  fb_wr_t i_push_data,
  input  logic   i_pop,
  output fb_wr_t o_pop_data,
  output logic   o_full,
  output logic   o_empty
);

  localparam int             PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  fb_wr_t         r_mem [DEPTH];
  logic [PTR_W:0] r_wr_ptr;
  logic [PTR_W:0] r_rd_ptr;
  logic           w_do_push;
  logic           w_do_pop;

  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                      (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign o_pop_data = r_mem[r_rd_ptr[PTR_W-1:0]];

  // A simultaneous pop frees the slot, so a push into a full FIFO is still taken.
  assign w_do_push = i_push && (!o_full || i_pop);
  assign w_do_pop  = i_pop && !o_empty;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_16mhz) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is not reset; pointers alone define validity, which keeps it RAM-mappable.
  always_ff @(posedge clk_16mhz) begin
    if (w_do_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/mac_fb_scanout.sv
// Framebuffer arbiter and pixel serialiser: scanout reads beat deferred dither writes.
// Optional MAC_FB_DROP_COUNT_EN adds a saturating drop_count output.
module mac_fb_scanout
  import mac_fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = FB_ADDR_W
) (
  input  logic        clk_16mhz,
  input  logic        reset,
  input  logic        wr_valid,
  input  logic [11:0] wr_xaddr,
  input  logic [11:0] wr_yaddr,
  input  logic [15:0] wr_bits,
  output logic        wr_overflow,
  input  logic [9:0]  scan_xaddr,
  input  logic [8:0]  scan_yaddr,
  output logic        video_bit,
`ifdef MAC_FB_DROP_COUNT_EN
  output logic [15:0] drop_count,
`endif
  mac_fb_scanout_if.master fb
);

  slot_state_e       r_state;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_wen;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [15:0]       r_wr_data;
  logic [15:0]       r_shreg;
  logic              r_video;
  logic              r_overflow;

  slot_state_e w_state;
  logic        w_in_range;
  logic        w_push;
  logic        w_pop;
  logic        w_drop;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  fb_wr_t      w_push_data;
  fb_wr_t      w_head;
  logic        w_unused;

  // A word fetch is issued whenever the beam sits on a 16-pixel boundary; the
  // cycle after a fetch latches the returned word into the shifter.
  // NOTE: default assigned first so every path drives w_state and no latch is inferred.
  always_comb begin
    w_state = IDLE;
    if (scan_xaddr[3:0] == 4'd0) begin
      w_state = READ;
    end else if (r_state == READ) begin
      w_state = LOAD;
    end
  end

  assign w_in_range  = (wr_xaddr[11:9] == 3'd0) && (wr_yaddr[11:9] == 3'd0);
  assign w_push      = wr_valid && w_in_range;
  assign w_pop       = (w_state != READ) && !w_fifo_empty;
  assign w_drop      = w_push && w_fifo_full && !w_pop;
  assign w_push_data = '{addr: fb_word_addr(wr_yaddr[8:0], wr_xaddr[8:0]), data: wr_bits};

  mac_fb_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk_16mhz   (clk_16mhz),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  always_ff @(posedge clk_16mhz) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rd_addr  <= '0;
      r_wen      <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_shreg    <= '0;
      r_video    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_wen      <= w_pop;
      r_overflow <= w_drop;

      if (w_pop) begin
        r_wr_addr <= w_head.addr;
        r_wr_data <= w_head.data;
      end

      if (w_state == READ) begin
        r_rd_addr <= fb_word_addr(scan_yaddr, scan_xaddr[8:0]);
      end

      // The last pixel of the previous word still shifts out during a fetch cycle.
      if (w_state == LOAD) begin
        r_shreg <= {fb.fb_rd_data[14:0], 1'b0};
        r_video <= fb.fb_rd_data[15];
      end else begin
        r_shreg <= {r_shreg[14:0], 1'b0};
        r_video <= r_shreg[15];
      end
    end
  end

`ifdef MAC_FB_DROP_COUNT_EN
  logic [15:0] r_drop_count;

  always_ff @(posedge clk_16mhz) begin
    if (reset) begin
      r_drop_count <= '0;
    end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign drop_count = r_drop_count;
`endif

  assign fb.fb_wen     = r_wen;
  assign fb.fb_wr_addr = r_wr_addr;
  assign fb.fb_wr_data = r_wr_data;
  assign fb.fb_rd_addr = r_rd_addr;
  assign video_bit     = r_video;
  assign wr_overflow   = r_overflow;

  // Sub-word x bits and the scan x MSB carry no addressing information here.
  assign w_unused = ^{scan_xaddr[9], wr_xaddr[3:0]};

endmodule
